mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu_pkg.sv | 31 +++
 rtl/mdu_calc.sv | 58 +++++
 rtl/mdu.sv | 106 ++++++++++
 tb/tb_mdu.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared pipeline definitions for the multiply/divide unit: op encodings,
// FSM state encoding and default latencies.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_mult(input mdu_op_e op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div(input mdu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational result generator: 64-bit products and signed/unsigned
// quotient/remainder packed as {HI, LO}.
module mdu_calc
    import mdu_pkg::*;
(
    input  mdu_op_e     op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [63:0] result,
    output logic        write_en
);

    logic        signed_div;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quo_u;
    logic [31:0] rem_u;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        result     = '0;
        write_en   = 1'b0;
        signed_div = (op == OP_DIV);
        neg_a      = signed_div & src_a[31];
        neg_b      = signed_div & src_b[31];
        mag_a      = neg_a ? (~src_a + 32'd1) : src_a;
        mag_b      = neg_b ? (~src_b + 32'd1) : src_b;
        quo_u      = '0;
        rem_u      = '0;

        if (src_b != '0) begin
            quo_u = mag_a / mag_b;
            rem_u = mag_a % mag_b;
        end

        case (op)
            OP_MULT: begin
                result   = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
                write_en = 1'b1;
            end
            OP_MULTU: begin
                result   = {32'd0, src_a} * {32'd0, src_b};
                write_en = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                // Divide by zero leaves HI/LO untouched. 0x80000000 / -1 falls out
                // of the magnitude path as 0x80000000 with remainder 0.
                write_en      = (src_b != '0);
                result[31:0]  = (neg_a ^ neg_b) ? (~quo_u + 32'd1) : quo_u;
                result[63:32] = neg_a ? (~rem_u + 32'd1) : rem_u;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit: IDLE/BUSY FSM, latency counter, pending
// result and architectural HI/LO registers.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [63:0]      pending_q, pending_d;

    mdu_op_e     op;
    logic [63:0] calc_result;
    logic        calc_write;
    logic        commit;

    assign op     = mdu_op_e'(MDUOp);
    assign commit = (state_q == ST_BUSY) && (cnt_q == CNT_W'(1));
    assign HI     = hi_q;
    assign LO     = lo_q;

    mdu_calc u_calc (
        .op       (op),
        .src_a    (SrcA),
        .src_b    (SrcB),
        .result   (calc_result),
        .write_en (calc_write)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pending_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values together.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (Start && is_mult(op)) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_W'(MULT_CYCLES);
                end else if (Start && is_div(op)) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_W'(DIV_CYCLES);
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (commit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Busy is the state flop itself; Start and MT* are ignored while BUSY.
    always_comb begin
        Busy      = (state_q == ST_BUSY);
        hi_d      = hi_q;
        lo_d      = lo_q;
        pending_d = pending_q;
        if (state_q == ST_IDLE) begin
            if (Start && (is_mult(op) || is_div(op))) begin
                pending_d = calc_write ? calc_result : {hi_q, lo_q};
            end else if (Start && (op == OP_MTHI)) begin
                hi_d = SrcA;
            end else if (Start && (op == OP_MTLO)) begin
                lo_d = SrcA;
            end
        end else if (commit) begin
            {hi_d, lo_d} = pending_q;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed corner cases plus random ops, with a
// scoreboard of expected commits checked by an independent monitor.
module tb_mdu;
    import mdu_pkg::*;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDUOp;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    mdu #(.MULT_CYCLES(MULT_CYC), .DIV_CYCLES(DIV_CYC)) dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDUOp (MDUOp),
        .SrcA  (SrcA),
        .SrcB  (SrcB),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    int          run_len  = 0;
    logic [31:0] hi_m, lo_m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    function automatic logic [63:0] ref_op(input mdu_op_e op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
        longint          sa, sb_, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     res;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        res = {hi, lo};
        case (op)
            OP_MULT:  res = sa * sb_;
            OP_MULTU: res = ua * ub;
            OP_DIV: if (b != 0) begin
                q   = sa / sb_;
                r   = sa % sb_;
                res = {r[31:0], q[31:0]};
            end
            OP_DIVU: if (b != 0) begin
                uq  = ua / ub;
                ur  = ua % ub;
                res = {ur[31:0], uq[31:0]};
            end
            default: ;
        endcase
        return res;
    endfunction

    // Monitor: a falling Busy (outside reset) is a commit; compare against scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            run_len = 0;
        end else if (Busy) begin
            run_len++;
        end else if (run_len > 0) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_commit: got busy run %0d expected none", run_len);
            end else begin
                mon_e = sb.pop_front();
                check("busy_cycles", 64'(run_len), 64'(mon_e.cycles));
                check("commit_hi", {32'd0, HI}, {32'd0, mon_e.hi});
                check("commit_lo", {32'd0, LO}, {32'd0, mon_e.lo});
            end
            run_len = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (Busy && n < 100) begin
            tick();
            n++;
        end
        if (Busy) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got Busy=1 expected Busy=0 within 100 cycles", name);
        end
        tick();
    endtask

    task automatic issue(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        logic        md;
        md    = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
        Start = 1'b1;
        MDUOp = op;
        SrcA  = a;
        SrcB  = b;
        if (md) begin
            r = ref_op(op, a, b, hi_m, lo_m);
            sb.push_back('{((op == OP_MULT) || (op == OP_MULTU)) ? MULT_CYC : DIV_CYC,
                           r[63:32], r[31:0]});
            hi_m = r[63:32];
            lo_m = r[31:0];
        end else if (op == OP_MTHI) begin
            hi_m = a;
        end else if (op == OP_MTLO) begin
            lo_m = a;
        end
        tick();
        Start = 1'b0;
        MDUOp = OP_NONE;
        if (md) begin
            check("busy_rise", {63'd0, Busy}, 64'd1);
            wait_idle("op");
        end else begin
            check("nobusy", {63'd0, Busy}, 64'd0);
            check("direct_hi", {32'd0, HI}, {32'd0, hi_m});
            check("direct_lo", {32'd0, LO}, {32'd0, lo_m});
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        Start = 1'b0;
        MDUOp = OP_NONE;
        SrcA  = '0;
        SrcB  = '0;
        hi_m  = '0;
        lo_m  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {63'd0, Busy}, 64'd0);
        check("reset_hi", {32'd0, HI}, 64'd0);
        check("reset_lo", {32'd0, LO}, 64'd0);
        reset = 1'b0;
        tick();

        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        check("mult_hi", {32'd0, HI}, 64'hFFFF_FFFF);
        check("mult_lo", {32'd0, LO}, 64'hFFFF_FFFA);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_hi", {32'd0, HI}, 64'hFFFF_FFFE);
        check("multu_lo", {32'd0, LO}, 64'h0000_0001);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_hi", {32'd0, HI}, 64'hFFFF_FFFF);
        check("div_lo", {32'd0, LO}, 64'hFFFF_FFFD);

        issue(OP_DIVU, 32'd7, 32'd2);
        check("divu_hi", {32'd0, HI}, 64'd1);
        check("divu_lo", {32'd0, LO}, 64'd3);

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("divovf_hi", {32'd0, HI}, 64'd0);
        check("divovf_lo", {32'd0, LO}, 64'h8000_0000);

        issue(OP_MTHI, 32'h11, 32'd0);
        issue(OP_MTLO, 32'h22, 32'd0);
        issue(OP_DIV, 32'd1234, 32'd0);
        check("div0_hi", {32'd0, HI}, 64'h11);
        check("div0_lo", {32'd0, LO}, 64'h22);

        issue(OP_NONE, 32'hDEAD_BEEF, 32'd5);

        // Start during Busy: a DIV request in the second busy cycle must be dropped.
        Start = 1'b1;
        MDUOp = OP_MULT;
        SrcA  = 32'd6;
        SrcB  = 32'd7;
        sb.push_back('{MULT_CYC, 32'd0, 32'd42});
        hi_m = 32'd0;
        lo_m = 32'd42;
        tick();
        Start = 1'b0;
        MDUOp = OP_NONE;
        tick();
        Start = 1'b1;
        MDUOp = OP_DIV;
        SrcA  = 32'd100;
        SrcB  = 32'd3;
        tick();
        Start = 1'b0;
        MDUOp = OP_NONE;
        wait_idle("busy_start");
        check("ignored_hi", {32'd0, HI}, 64'd0);
        check("ignored_lo", {32'd0, LO}, 64'd42);
        repeat (3) tick();
        check("ignored_busy_low", {63'd0, Busy}, 64'd0);

        for (int i = 0; i < 40; i++) begin
            issue(mdu_op_e'($urandom_range(0, 6)), pick(), pick());
        end

        // Reset in the third busy cycle of a DIV aborts it with no later commit.
        Start = 1'b1;
        MDUOp = OP_DIV;
        SrcA  = 32'd99;
        SrcB  = 32'd4;
        tick();
        Start = 1'b0;
        MDUOp = OP_NONE;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("abort_busy", {63'd0, Busy}, 64'd0);
        check("abort_hi", {32'd0, HI}, 64'd0);
        check("abort_lo", {32'd0, LO}, 64'd0);
        tick();
        reset = 1'b0;
        repeat (15) tick();
        check("post_abort_busy", {63'd0, Busy}, 64'd0);
        check("post_abort_hi", {32'd0, HI}, 64'd0);
        check("post_abort_lo", {32'd0, LO}, 64'd0);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
